// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   localparam int BYTES_PER_INSTR     = 4;
   localparam int IDX_W               = $clog2(BYTES_PER_INSTR);
   localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/fetch_byte_packer.sv
// Four-slot byte register that assembles a big-endian 32-bit instruction.
// Slot 0 lands in word[31:24], slot 3 in word[7:0].
module fetch_byte_packer
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_byte,
   output logic [31:0]      word
);

   logic [7:0] slot [BYTES_PER_INSTR];

   // Clear wins over a write so a discarded partial fetch never leaks through.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < BYTES_PER_INSTR; i++) begin
            slot[i] <= '0;
         end
      end else if (wr_en) begin
         slot[wr_idx] <= wr_byte;
      end
   end

   assign word = {slot[0], slot[1], slot[2], slot[3]};

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-wide instruction fetch sequencer: reads four bytes per instruction,
// presents the assembled word with a valid/ready handshake.
// Optional build macro: FETCH_TIMEOUT_EN adds a mem_ack wait timeout with a
// sticky err flag; without it the sequencer waits on memory indefinitely.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; waits for start
// FETCH | requesting byte pc+idx; each mem_ack stores one byte
// HOLD  | instruction complete; instr/instr_pc held until instr_ready
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_data,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              busy,
   output logic              err
);

   fetch_state_e      state;
   fetch_state_e      state_next;
   logic [ADDR_W-1:0] pc;
   logic [IDX_W-1:0]  idx;
   logic              ack_take;
   logic              handshake;
   logic              timeout_hit;
   logic              fetch_allowed;

`ifdef FETCH_TIMEOUT_EN
   localparam int            TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] wait_cnt;
   logic          lockout;
   logic          err_q;

   // Down-counter reloads whenever a wait period restarts; terminal count
   // with no ack ends the fetch and locks out restarts until a pc_load.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= WAIT_LOAD;
         lockout  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (state != FETCH || mem_ack || pc_load) begin
            wait_cnt <= WAIT_LOAD;
         end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if (pc_load) begin
            lockout <= 1'b0;
         end else if (timeout_hit) begin
            lockout <= 1'b1;
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign timeout_hit   = (state == FETCH) && !mem_ack && !pc_load && (wait_cnt == '0);
   assign fetch_allowed = !lockout;
   assign err           = err_q;
`else
   assign timeout_hit   = 1'b0;
   assign fetch_allowed = 1'b1;
   assign err           = 1'b0;
`endif

   // Next-state decode; pc_load pre-empts every other event, including a
   // same-cycle mem_ack or consumer handshake.
   always_comb begin
      state_next = state;
      ack_take   = 1'b0;
      handshake  = 1'b0;
      if (pc_load) begin
         state_next = start ? FETCH : IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start && fetch_allowed) begin
                  state_next = FETCH;
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  ack_take = 1'b1;
                  if (idx == IDX_W'(BYTES_PER_INSTR - 1)) begin
                     state_next = HOLD;
                  end
               end else if (timeout_hit) begin
                  state_next = IDLE;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  handshake  = 1'b1;
                  state_next = start ? FETCH : IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State, PC and byte index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc    <= RESET_PC;
         idx   <= '0;
      end else begin
         state <= state_next;
         if (pc_load) begin
            pc  <= pc_load_addr;
            idx <= '0;
         end else if (ack_take) begin
            idx <= idx + 1'b1;
         end else if (handshake) begin
            pc  <= pc + ADDR_W'(BYTES_PER_INSTR);
            idx <= '0;
         end else if (timeout_hit) begin
            idx <= '0;
         end
      end
   end

   fetch_byte_packer u_packer (
      .clk     (clk),
      .clear   (rst | pc_load),
      .wr_en   (ack_take),
      .wr_idx  (idx),
      .wr_byte (mem_data),
      .word    (instr)
   );

   // pc only moves on handshake or redirect, both of which leave HOLD, so
   // it still names byte 0 of the held instruction.
   assign mem_req     = (state == FETCH);
   assign mem_addr    = pc + ADDR_W'(idx);
   assign instr_valid = (state == HOLD);
   assign instr_pc    = pc;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized run scored against a word-level memory model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        pc_load;
   logic [7:0]  pc_load_addr;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instr_pc;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem_img [256];
   int         ack_wait = 0;   // -1: never ack, -2: random 0..3 per byte
   int         cur_wait = 0;
   int         pend     = 0;
   bit         noise    = 1'b0;
   logic [7:0] ack_log [$];

   fetch_sequencer #(
      .ADDR_W      (8),
      .RESET_PC    (8'h00),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .pc_load      (pc_load),
      .pc_load_addr (pc_load_addr),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_data     (mem_data),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_pc     (instr_pc),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   function automatic int pick_wait();
      if (ack_wait == -2) return $urandom_range(0, 3);
      return ack_wait;
   endfunction

   function automatic logic [31:0] exp_word(input logic [7:0] pc);
      logic [7:0] a1, a2, a3;
      a1 = pc + 8'd1;
      a2 = pc + 8'd2;
      a3 = pc + 8'd3;
      return {mem_img[pc], mem_img[a1], mem_img[a2], mem_img[a3]};
   endfunction

   task automatic set_wait(input int w);
      ack_wait = w;
      cur_wait = pick_wait();
      pend     = 0;
   endtask

   // Advance to the next falling edge and play the memory side.
   task automatic tick();
      @(negedge clk);
      if (mem_req === 1'b1) begin
         if (ack_wait != -1 && pend >= cur_wait) begin
            mem_ack  = 1'b1;
            mem_data = mem_img[mem_addr];
            ack_log.push_back(mem_addr);
            pend     = 0;
            cur_wait = pick_wait();
         end else begin
            mem_ack  = 1'b0;
            mem_data = 8'($urandom);
            pend++;
         end
      end else begin
         pend     = 0;
         mem_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_data = 8'($urandom);
      end
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      start       = 1'b0;
      pc_load     = 1'b0;
      instr_ready = 1'b0;
      noise       = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      ack_log.delete();
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      start        = 1'b0;
      pc_load      = 1'b0;
      pc_load_addr = 8'h00;
      instr_ready  = 1'b0;
      mem_ack      = 1'b0;
      mem_data     = 8'h00;
      tick();
      tick();
      checks += 7;
      if (instr !== 32'h0)       begin errors++; $display("FAIL reset_instr got %h exp %h", instr, 32'h0); end
      if (instr_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
      if (mem_req !== 1'b0)      begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      if (mem_addr !== 8'h00)    begin errors++; $display("FAIL reset_mem_addr got %h exp 00", mem_addr); end
      if (instr_pc !== 8'h00)    begin errors++; $display("FAIL reset_instr_pc got %h exp 00", instr_pc); end
      if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (err !== 1'b0)          begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      rst = 1'b0;
      ack_log.delete();
   endtask

   task automatic test_basic();
      int n;
      logic [31:0] addrs;
      for (int i = 0; i < 256; i++) mem_img[i] = 8'(i + 16);
      do_reset();
      set_wait(0);
      start = 1'b1;
      n = 0;
      while (instr_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      addrs = '1;
      for (int i = 0; i < ack_log.size() && i < 4; i++) addrs[31-8*i -: 8] = ack_log[i];
      checks += 7;
      if (n != 5)                 begin errors++; $display("FAIL basic_latency got %0d exp 5", n); end
      if (ack_log.size() != 4)    begin errors++; $display("FAIL basic_ack_count got %0d exp 4", ack_log.size()); end
      if (addrs !== 32'h00010203) begin errors++; $display("FAIL basic_addrs got %h exp 00010203", addrs); end
      if (instr !== 32'h10111213) begin errors++; $display("FAIL basic_instr got %h exp 10111213", instr); end
      if (instr_pc !== 8'h00)     begin errors++; $display("FAIL basic_instr_pc got %h exp 00", instr_pc); end
      if (busy !== 1'b1)          begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
      if (mem_req !== 1'b0)       begin errors++; $display("FAIL basic_hold_req got %b exp 0", mem_req); end
   endtask

   task automatic test_hold();
      logic [31:0] held;
      bit stable_ok;
      int n;
      held = instr;
      stable_ok = 1'b1;
      instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (instr !== held || mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 8'h00)
            stable_ok = 1'b0;
      end
      checks++;
      if (!stable_ok) begin errors++; $display("FAIL hold_stable got 0 exp 1"); end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks += 3;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b exp 0", instr_valid); end
      if (mem_req !== 1'b1)     begin errors++; $display("FAIL hold_next_req got %b exp 1", mem_req); end
      if (mem_addr !== 8'h04)   begin errors++; $display("FAIL hold_next_addr got %h exp 04", mem_addr); end
      n = 0;
      while (instr_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checks += 2;
      if (instr !== 32'h14151617) begin errors++; $display("FAIL hold_second_instr got %h exp 14151617", instr); end
      if (instr_pc !== 8'h04)     begin errors++; $display("FAIL hold_second_pc got %h exp 04", instr_pc); end
   endtask

   task automatic test_pc_load();
      int n;
      logic [31:0] addrs;
      for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
      do_reset();
      set_wait(0);
      start = 1'b1;
      n = 0;
      while (!(mem_req === 1'b1 && mem_addr === 8'h02) && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL pcload_reach_idx2 got timeout exp addr 02"); end
      pc_load      = 1'b1;
      pc_load_addr = 8'hFE;
      ack_log.delete();
      tick();
      pc_load = 1'b0;
      checks += 2;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL pcload_valid got %b exp 0", instr_valid); end
      if (mem_addr !== 8'hFE)   begin errors++; $display("FAIL pcload_first_addr got %h exp fe", mem_addr); end
      n = 0;
      while (instr_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      addrs = '0;
      for (int i = 0; i < ack_log.size() && i < 4; i++) addrs[31-8*i -: 8] = ack_log[i];
      checks += 4;
      if (ack_log.size() != 4)       begin errors++; $display("FAIL pcload_ack_count got %0d exp 4", ack_log.size()); end
      if (addrs !== 32'hFEFF0001)    begin errors++; $display("FAIL pcload_wrap_addrs got %h exp feff0001", addrs); end
      if (instr_pc !== 8'hFE)        begin errors++; $display("FAIL pcload_instr_pc got %h exp fe", instr_pc); end
      if (instr !== exp_word(8'hFE)) begin errors++; $display("FAIL pcload_instr got %h exp %h", instr, exp_word(8'hFE)); end
   endtask

   task automatic test_wait();
      int n;
      bit hold_ok, prev_req, prev_ack;
      logic [7:0] prev_addr;
      logic [31:0] addrs;
      do_reset();
      set_wait(3);
      start = 1'b1;
      n = 0;
      hold_ok = 1'b1;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      prev_addr = 8'h00;
      while (instr_valid !== 1'b1 && n < 60) begin
         tick();
         n++;
         if (prev_req && !prev_ack && mem_req === 1'b1 && mem_addr !== prev_addr) hold_ok = 1'b0;
         prev_req  = (mem_req === 1'b1);
         prev_ack  = (mem_ack === 1'b1);
         prev_addr = mem_addr;
      end
      addrs = '1;
      for (int i = 0; i < ack_log.size() && i < 4; i++) addrs[31-8*i -: 8] = ack_log[i];
      checks += 4;
      if (!hold_ok)                  begin errors++; $display("FAIL wait_addr_hold got 0 exp 1"); end
      if (n != 17)                   begin errors++; $display("FAIL wait_latency got %0d exp 17", n); end
      if (addrs !== 32'h00010203)    begin errors++; $display("FAIL wait_addrs got %h exp 00010203", addrs); end
      if (instr !== exp_word(8'h00)) begin errors++; $display("FAIL wait_instr got %h exp %h", instr, exp_word(8'h00)); end
   endtask

   task automatic test_timeout();
      bit ok;
      do_reset();
      set_wait(-1);
      start = 1'b1;
      ok = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         tick();
         if (err !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      end
      tick();
      checks += 4;
      if (!ok)              begin errors++; $display("FAIL timeout_early got 0 exp 1"); end
      if (err !== 1'b1)     begin errors++; $display("FAIL timeout_err got %b exp 1", err); end
      if (busy !== 1'b0)    begin errors++; $display("FAIL timeout_busy got %b exp 0", busy); end
      if (mem_req !== 1'b0) begin errors++; $display("FAIL timeout_req got %b exp 0", mem_req); end
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (busy !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL timeout_lockout got 0 exp 1"); end
      pc_load      = 1'b1;
      pc_load_addr = 8'h20;
      tick();
      pc_load = 1'b0;
      checks += 3;
      if (mem_req !== 1'b1)   begin errors++; $display("FAIL timeout_reload_req got %b exp 1", mem_req); end
      if (mem_addr !== 8'h20) begin errors++; $display("FAIL timeout_reload_addr got %h exp 20", mem_addr); end
      if (err !== 1'b1)       begin errors++; $display("FAIL timeout_sticky got %b exp 1", err); end
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         if (err !== 1'b0 || busy !== 1'b1 || mem_req !== 1'b1) ok = 1'b0;
      end
      checks += 2;
      if (!ok)                begin errors++; $display("FAIL nowait_limit_stable got 0 exp 1"); end
      if (mem_addr !== 8'h00) begin errors++; $display("FAIL nowait_limit_addr got %h exp 00", mem_addr); end
`endif
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      set_wait(0);
      start        = 1'b1;
      pc_load      = 1'b1;
      pc_load_addr = 8'h40;
      tick();
      pc_load = 1'b0;
      n = 0;
      while (!(mem_req === 1'b1 && mem_addr === 8'h41) && n < 20) begin
         tick();
         n++;
      end
      rst          = 1'b1;
      pc_load      = 1'b1;
      pc_load_addr = 8'h80;
      tick();
      checks += 7;
      if (instr !== 32'h0)      begin errors++; $display("FAIL rstmid_instr got %h exp 0", instr); end
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", instr_valid); end
      if (mem_req !== 1'b0)     begin errors++; $display("FAIL rstmid_req got %b exp 0", mem_req); end
      if (mem_addr !== 8'h00)   begin errors++; $display("FAIL rstmid_addr got %h exp 00", mem_addr); end
      if (instr_pc !== 8'h00)   begin errors++; $display("FAIL rstmid_instr_pc got %h exp 00", instr_pc); end
      if (busy !== 1'b0)        begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
      if (err !== 1'b0)         begin errors++; $display("FAIL rstmid_err got %b exp 0", err); end
      rst     = 1'b0;
      pc_load = 1'b0;
   endtask

   // Word-level model: the next instruction delivered is always the four
   // bytes at exp_pc; a redirect moves exp_pc, an accepted word adds 4.
   task automatic test_random();
      logic [7:0] exp_pc;
      logic [7:0] off;
      int accepted;
      for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
      do_reset();
      set_wait(-2);
      noise = 1'b1;
      exp_pc = 8'h00;
      accepted = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         checks++;
         if (busy !== (mem_req | instr_valid)) begin
            errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", cyc, busy, mem_req | instr_valid);
         end
         if (mem_req === 1'b1) begin
            off = mem_addr - exp_pc;
            checks++;
            if (off > 8'd3) begin errors++; $display("FAIL rand_mem_addr cyc %0d got %h exp %h..+3", cyc, mem_addr, exp_pc); end
         end
         if (instr_valid === 1'b1) begin
            checks += 2;
            if (instr !== exp_word(exp_pc)) begin errors++; $display("FAIL rand_instr cyc %0d got %h exp %h", cyc, instr, exp_word(exp_pc)); end
            if (instr_pc !== exp_pc)        begin errors++; $display("FAIL rand_instr_pc cyc %0d got %h exp %h", cyc, instr_pc, exp_pc); end
         end
         start        = ($urandom_range(0, 9) != 0);
         instr_ready  = 1'($urandom_range(0, 1));
         pc_load      = ($urandom_range(0, 40) == 0);
         pc_load_addr = 8'($urandom);
         if (pc_load) begin
            exp_pc = pc_load_addr;
         end else if (instr_valid === 1'b1 && instr_ready) begin
            exp_pc = exp_pc + 8'd4;
            accepted++;
         end
      end
      checks++;
      if (accepted < 50) begin errors++; $display("FAIL rand_progress got %0d exp >=50", accepted); end
      noise       = 1'b0;
      pc_load     = 1'b0;
      instr_ready = 1'b0;
      start       = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_pc_load();
      test_wait();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width of instruction memory.
REQ-002 Parameter RESET_PC, default 0, PC value after reset.
REQ-003 Parameter TIMEOUT_CYC, default 16, max cycles waiting for mem_ack (used only with FETCH_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  level; fetching permitted while high.
REQ-007 pc_load  in  1  one-cycle pulse; redirect PC.
REQ-008 pc_load_addr  in  ADDR_W  new PC when pc_load=1.
REQ-009 mem_req  out  1  byte read request to instruction memory.
REQ-010 mem_addr  out  ADDR_W  byte address being requested.
REQ-011 mem_ack  in  1  memory accepted request; mem_data valid this cycle.
REQ-012 mem_data  in  8  returned byte.
REQ-013 instr  out  32  assembled instruction.
REQ-014 instr_valid  out  1  instr/instr_pc valid.
REQ-015 instr_ready  in  1  consumer accepts instr.
REQ-016 instr_pc  out  ADDR_W  address of instr byte 0.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 err  out  1  sticky fetch-timeout flag.

Function
REQ-019 FSM SHALL have states IDLE, FETCH, HOLD.
REQ-020 IDLE: mem_req=0, instr_valid=0; go FETCH on start=1.
REQ-021 FETCH: mem_req=1, mem_addr=(pc+idx) mod 2^ADDR_W, idx = 2-bit byte index 0..3.
REQ-022 On mem_ack in FETCH, mem_data SHALL be stored big-endian: idx0->instr[31:24], idx1->[23:16], idx2->[15:8], idx3->[7:0]; idx increments.
REQ-023 mem_ack with idx=3 SHALL move to HOLD; instr_valid=1 from the next cycle; minimum latency FETCH entry to instr_valid = 4 cycles with zero-wait memory.
REQ-024 mem_ack SHALL be ignored outside FETCH.
REQ-025 HOLD: instr, instr_pc, instr_valid stable until instr_ready=1.
REQ-026 instr_valid & instr_ready: pc <= pc+4 mod 2^ADDR_W, idx<=0, next state FETCH if start=1 else IDLE.
REQ-027 start deasserted mid-FETCH SHALL NOT abort; current instruction completes into HOLD.
REQ-028 pc_load=1 SHALL take priority over all other events in any state: pc<=pc_load_addr, idx<=0, instr_valid<=0, mem_ack of that cycle discarded, next state FETCH if start=1 else IDLE.
REQ-029 pc_load coincident with instr_ready in HOLD: handshake dropped, pc_load wins.
REQ-030 Address wrap: byte addresses beyond 2^ADDR_W-1 SHALL wrap to 0 within one instruction.
REQ-031 instr_pc SHALL equal pc latched at start of the instruction's fetch.

Reset
REQ-032 On rst: state=IDLE, pc=RESET_PC, idx=0, instr=0, instr_valid=0, mem_req=0, mem_addr=RESET_PC, instr_pc=RESET_PC, busy=0, err=0.
REQ-033 rst mid-fetch SHALL discard partial bytes; rst overrides pc_load.

Configuration
REQ-034 Macro FETCH_TIMEOUT_EN defined: wait counter clears on each mem_ack/state entry; reaching TIMEOUT_CYC cycles without mem_ack in FETCH sets err=1 (sticky until rst), drops request, goes IDLE; FETCH re-entered only after pc_load.
REQ-035 Macro undefined: no counter, FETCH waits indefinitely, err tied 0.

Structure
REQ-036 Package fetch_pkg SHALL hold state enum (IDLE, FETCH, HOLD), BYTES_PER_INSTR=4, default TIMEOUT_CYC.
REQ-037 Sub-module fetch_byte_packer SHALL hold the 4-slot byte register (write enable, index, byte in, clear, 32-bit out); FSM and PC remain in fetch_sequencer.

Verification
REQ-038 Reset, start=1, zero-wait memory returning addr+0x10 -> mem_addr 0,1,2,3; instr=0x10111213, instr_pc=0, instr_valid on cycle 5.
REQ-039 instr_ready held 0 for 10 cycles -> instr stable, mem_req=0; ready=1 -> next fetch at addr 4.
REQ-040 pc_load=1, addr=0xFE, during idx=2 -> partial discarded; fetch 0xFE,0xFF,0x00,0x01; instr_pc=0xFE.
REQ-041 mem_ack delayed 3 cycles per byte -> mem_req/mem_addr held; instr correct after 16 cycles.
REQ-042 FETCH_TIMEOUT_EN, TIMEOUT_CYC=16, mem_ack never -> err=1 after 16 cycles, state IDLE, busy=0; without macro -> busy=1, err=0 indefinitely.
REQ-043 rst asserted at idx=1 -> all outputs per REQ-032 next cycle.
